// File: rtl/aexm_fetch_ctrl.sv
// aeMB instruction-fetch sequencer: pipeline enable, I-cache miss detect, line refill.
// Optional refill watchdog enabled with `define AEXM_FETCH_TIMEOUT_EN.
module aexm_fetch_ctrl #(
  parameter int IW  = 24,
  parameter int LW  = 2,
  parameter int TMO = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          cpu_run,
  input  logic          dstall,
  input  logic [IW-1:2] ic_addr,
  input  logic          ic_miss,
  output logic          gena,
  output logic          mem_req,
  output logic [IW-1:2] mem_adr,
  input  logic          mem_gnt,
  input  logic          mem_dvalid,
  input  logic [31:0]   mem_dat,
  output logic          ic_we,
  output logic [IW-1:2] ic_wadr,
  output logic [31:0]   ic_wdat,
  output logic          ic_vld_we,
  output logic [15:0]   miss_cnt,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    RESUME = 2'd3
  } state_t;

  state_t state;
  state_t nextState;

  logic [IW-1:2+LW] line;
  logic [LW-1:0]    cnt;
  logic [15:0]      missCnt;
  logic             missHit;
  logic             lastWord;
  logic             tmoHit;

  assign missHit  = (state == RUN) & cpu_run & ic_miss;
  assign lastWord = (state == FILL) & mem_dvalid
                  & (cnt == {LW{1'b1}});

  // Word offset within the line is supplied by the fill counter.
  logic unusedLowAddr;
  assign unusedLowAddr = ^ic_addr[LW+1:2];

`ifdef AEXM_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  localparam int WW = (TW > 8) ? TW : 8;

  logic [WW-1:0] wdog;
  logic          waiting;

  assign waiting = ((state == REQ) & ~mem_gnt)
                 | ((state == FILL) & ~mem_dvalid);
  assign tmoHit  = waiting & (wdog == WW'(TMO - 1));

  // Counts consecutive stalled handshake cycles.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      wdog <= '0;
    end else if (~waiting | tmoHit
                 | (nextState != state)) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  logic [7:0] unusedTmo;
  assign unusedTmo = 8'(TMO);
  assign tmoHit    = 1'b0;
`endif

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      RUN: begin
        if (missHit) nextState = REQ;
      end
      REQ: begin
        if (tmoHit)       nextState = REQ;
        else if (mem_gnt) nextState = FILL;
      end
      FILL: begin
        if (tmoHit)        nextState = REQ;
        else if (lastWord) nextState = RESUME;
      end
      RESUME: begin
        nextState = RUN;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      line <= '0;
    end else if (missHit) begin
      line <= ic_addr[IW-1:2+LW];
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      cnt <= '0;
    end else if (state == REQ) begin
      cnt <= '0;
    end else if (state == FILL) begin
      if (tmoHit) begin
        cnt <= '0;
      end else if (mem_dvalid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      missCnt <= '0;
    end else if (lastWord && (missCnt != 16'hFFFF)) begin
      missCnt <= missCnt + 16'd1;
    end
  end

  always_comb begin
    gena      = (state == RUN) & cpu_run & ~ic_miss
              & ~dstall & ~grst;
    mem_req   = ((state == REQ) | (state == FILL))
              & ~tmoHit;
    mem_adr   = {line, {LW{1'b0}}};
    ic_we     = (state == FILL) & mem_dvalid;
    ic_wadr   = {line, cnt};
    ic_wdat   = mem_dat;
    ic_vld_we = lastWord;
    miss_cnt  = missCnt;
    fetch_err = tmoHit;
  end

endmodule

// File: tb/tb_aexm_fetch_ctrl.sv
// Scoreboard bench for aexm_fetch_ctrl: directed misses, refill writes checked by monitor.
// Timeout behaviour is exercised when AEXM_FETCH_TIMEOUT_EN is defined.
module tb_aexm_fetch_ctrl;

  logic        gclk = 1'b0;
  logic        grst;
  logic        cpu_run;
  logic        dstall;
  logic [23:2] ic_addr;
  logic        ic_miss;
  logic        gena;
  logic        mem_req;
  logic [23:2] mem_adr;
  logic        mem_gnt;
  logic        mem_dvalid;
  logic [31:0] mem_dat;
  logic        ic_we;
  logic [23:2] ic_wadr;
  logic [31:0] ic_wdat;
  logic        ic_vld_we;
  logic [15:0] miss_cnt;
  logic        fetch_err;

  aexm_fetch_ctrl #(.IW(24), .LW(2), .TMO(8)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .cpu_run   (cpu_run),
    .dstall    (dstall),
    .ic_addr   (ic_addr),
    .ic_miss   (ic_miss),
    .gena      (gena),
    .mem_req   (mem_req),
    .mem_adr   (mem_adr),
    .mem_gnt   (mem_gnt),
    .mem_dvalid(mem_dvalid),
    .mem_dat   (mem_dat),
    .ic_we     (ic_we),
    .ic_wadr   (ic_wadr),
    .ic_wdat   (ic_wdat),
    .ic_vld_we (ic_vld_we),
    .miss_cnt  (miss_cnt),
    .fetch_err (fetch_err)
  );

  always #5 gclk = ~gclk;

  typedef struct packed {
    logic [21:0] a;
    logic [31:0] d;
    logic        v;
  } wr_t;

  wr_t expQ[$];
  wr_t cur;
  int  tests   = 0;
  int  fails   = 0;
  int  weCnt   = 0;
  int  expMiss = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: every cache write must match the next queued word.
  always @(negedge gclk) begin
    if (ic_we === 1'b1 || ic_vld_we === 1'b1) begin
      weCnt++;
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: adr %h vld %b expected none",
                 ic_wadr, ic_vld_we);
      end else begin
        cur = expQ.pop_front();
        chk("ic_wadr", 32'(ic_wadr), 32'(cur.a));
        chk("ic_wdat", ic_wdat, cur.d);
        chk("ic_vld_we", 32'(ic_vld_we), 32'(cur.v));
      end
    end
  end

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  task automatic startMiss(input logic [23:2] a,
                           input logic ds);
    ic_addr = a;
    ic_miss = 1'b1;
    dstall  = ds;
    #3;
    chk("miss_gena", 32'(gena), 32'd0);
    chk("miss_req", 32'(mem_req), 32'd0);
    tick();
    ic_miss = 1'b0;
  endtask

  task automatic waitGnt(input int dly,
                         input logic [23:2] adr);
    for (int i = 0; i < dly; i++) begin
      mem_gnt = 1'b0;
      #3;
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_adr", 32'(mem_adr), 32'(adr));
      chk("wait_gena", 32'(gena), 32'd0);
      chk("wait_err", 32'(fetch_err), 32'd0);
      tick();
    end
    mem_gnt = 1'b1;
    #3;
    chk("gnt_req", 32'(mem_req), 32'd1);
    chk("gnt_adr", 32'(mem_adr), 32'(adr));
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic fillLine(input int gap,
                          input logic [23:2] adr,
                          input logic [31:0] base);
    int w0;
    w0 = weCnt;
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < gap; g++) begin
        mem_dvalid = 1'b0;
        #3;
        chk("gap_req", 32'(mem_req), 32'd1);
        chk("gap_gena", 32'(gena), 32'd0);
        chk("gap_we", 32'(ic_we), 32'd0);
        tick();
      end
      mem_dvalid = 1'b1;
      mem_dat    = base + 32'(w);
      expQ.push_back('{a: adr + 22'(w),
                       d: base + 32'(w),
                       v: (w == 3)});
      #3;
      chk("fill_req", 32'(mem_req), 32'd1);
      chk("fill_gena", 32'(gena), 32'd0);
      tick();
    end
    mem_dvalid = 1'b0;
    chk("we_pulses", 32'(weCnt - w0), 32'd4);
  endtask

  task automatic finishMiss(input logic ds);
    expMiss++;
    #3;
    chk("resume_gena", 32'(gena), 32'd0);
    chk("resume_req", 32'(mem_req), 32'd0);
    tick();
    if (ds) begin
      #3;
      chk("run_dstall_gena", 32'(gena), 32'd0);
      chk("run_dstall_req", 32'(mem_req), 32'd0);
      tick();
      dstall = 1'b0;
    end
    #3;
    chk("run_gena", 32'(gena), 32'd1);
    chk("miss_cnt", 32'(miss_cnt), 32'(expMiss));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    grst       = 1'b1;
    cpu_run    = 1'b1;
    dstall     = 1'b0;
    ic_miss    = 1'b0;
    ic_addr    = '0;
    mem_gnt    = 1'b0;
    mem_dvalid = 1'b0;
    mem_dat    = '0;

    // Reset state
    #12;
    chk("rst_gena", 32'(gena), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_cnt", 32'(miss_cnt), 32'd0);
    tick();
    grst = 1'b0;
    #3;
    chk("post_rst_gena", 32'(gena), 32'd1);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_err", 32'(fetch_err), 32'd0);
    tick();

    // Zero-wait miss: line 001234, words AA0..AA3
    startMiss(22'h001235, 1'b0);
    waitGnt(0, 22'h001234);
    fillLine(0, 22'h001234, 32'h0000_0AA0);
    finishMiss(1'b0);

    // Slow grant and gapped data
    startMiss(22'h00ABCE, 1'b0);
    waitGnt(5, 22'h00ABCC);
    fillLine(2, 22'h00ABCC, 32'h5500_0010);
    finishMiss(1'b0);

    // Reset in the middle of a fill
    startMiss(22'h002349, 1'b0);
    waitGnt(0, 22'h002348);
    for (int w = 0; w < 2; w++) begin
      mem_dvalid = 1'b1;
      mem_dat    = 32'hDEAD_0000 + 32'(w);
      expQ.push_back('{a: 22'h002348 + 22'(w),
                       d: 32'hDEAD_0000 + 32'(w),
                       v: 1'b0});
      tick();
    end
    mem_dvalid = 1'b0;
    grst       = 1'b1;
    expMiss    = 0;
    #3;
    chk("midrst_gena", 32'(gena), 32'd0);
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_we", 32'(ic_we), 32'd0);
    chk("midrst_cnt", 32'(miss_cnt), 32'd0);
    tick();
    grst = 1'b0;
    #3;
    chk("rel_gena", 32'(gena), 32'd1);
    chk("rel_req", 32'(mem_req), 32'd0);
    tick();
    startMiss(22'h002349, 1'b0);
    waitGnt(1, 22'h002348);
    fillLine(0, 22'h002348, 32'hBEEF_0000);
    finishMiss(1'b0);

    // dstall alone stalls without a refill
    dstall = 1'b1;
    #3;
    chk("dstall_gena", 32'(gena), 32'd0);
    tick();
    dstall = 1'b0;
    #3;
    chk("dstall_noreq", 32'(mem_req), 32'd0);
    chk("dstall_rel_gena", 32'(gena), 32'd1);
    tick();

    // Miss ignored while cpu_run is low
    cpu_run = 1'b0;
    ic_miss = 1'b1;
    #3;
    chk("norun_gena", 32'(gena), 32'd0);
    tick();
    cpu_run = 1'b1;
    ic_miss = 1'b0;
    #3;
    chk("norun_noreq", 32'(mem_req), 32'd0);
    chk("norun_gena2", 32'(gena), 32'd1);
    tick();

    // Miss together with dstall, dstall held through the refill
    startMiss(22'h3FFFFF, 1'b1);
    waitGnt(2, 22'h3FFFFC);
    fillLine(1, 22'h3FFFFC, 32'h1234_5670);
    finishMiss(1'b1);

`ifdef AEXM_FETCH_TIMEOUT_EN
    // Grant withheld: watchdog fires on the 8th waiting cycle
    startMiss(22'h000102, 1'b0);
    for (int i = 0; i < 7; i++) begin
      #3;
      chk("tmo_wait_req", 32'(mem_req), 32'd1);
      chk("tmo_wait_err", 32'(fetch_err), 32'd0);
      tick();
    end
    #3;
    chk("tmo_err", 32'(fetch_err), 32'd1);
    chk("tmo_req_drop", 32'(mem_req), 32'd0);
    tick();
    #3;
    chk("tmo_rereq", 32'(mem_req), 32'd1);
    chk("tmo_readr", 32'(mem_adr), 32'h000100);
    chk("tmo_err_clr", 32'(fetch_err), 32'd0);
    tick();
    waitGnt(0, 22'h000100);
    fillLine(0, 22'h000100, 32'h7700_0000);
    finishMiss(1'b0);
`else
    // No watchdog: a long grant wait never raises fetch_err
    startMiss(22'h000102, 1'b0);
    waitGnt(40, 22'h000100);
    fillLine(0, 22'h000100, 32'h7700_0000);
    finishMiss(1'b0);
`endif

    chk("queue_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
